// File: rtl/seq_gen.sv
// Serial pattern transmitter: shifts an N-bit word out MSB-first, reps+1 times, then pulses done.
// Optional per-word even-parity bit enabled by defining SEQ_GEN_PARITY_EN.
module seq_gen #(
  parameter int N     = 3,
  parameter int REP_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [N-1:0]     seq,
  input  logic [REP_W-1:0] reps,
  output logic             ready,
  output logic             a,
  output logic             a_valid,
  output logic             busy,
  output logic             done
);

  localparam int unsigned BCW = $clog2(N + 1);
`ifdef SEQ_GEN_PARITY_EN
  localparam int unsigned LAST = N;
`else
  localparam int unsigned LAST = N - 1;
`endif

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state, state_n;
  logic [N-1:0]     pat_q, pat_n;
  logic [N-1:0]     shreg, shreg_n;
  logic [BCW-1:0]   bit_cnt, bit_cnt_n;
  logic [REP_W-1:0] rep_cnt, rep_cnt_n;
  logic             a_n, a_valid_n, busy_n, done_n;

  // The done cycle doubles as an accept slot so frames can run back-to-back.
  assign ready = (state == IDLE) || (state == DONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      pat_q   <= '0;
      shreg   <= '0;
      bit_cnt <= '0;
      rep_cnt <= '0;
      a       <= 1'b0;
      a_valid <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_n;
      pat_q   <= pat_n;
      shreg   <= shreg_n;
      bit_cnt <= bit_cnt_n;
      rep_cnt <= rep_cnt_n;
      a       <= a_n;
      a_valid <= a_valid_n;
      busy    <= busy_n;
      done    <= done_n;
    end
  end

  // Outputs are computed one cycle ahead so the registered a matches shreg's MSB.
  always_comb begin
    state_n   = state;
    pat_n     = pat_q;
    shreg_n   = shreg;
    bit_cnt_n = bit_cnt;
    rep_cnt_n = rep_cnt;
    a_n       = 1'b0;
    a_valid_n = 1'b0;
    busy_n    = 1'b0;
    done_n    = 1'b0;

    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_n   = SHIFT;
          pat_n     = seq;
          shreg_n   = seq;
          bit_cnt_n = '0;
          rep_cnt_n = reps;
          a_n       = seq[N-1];
          a_valid_n = 1'b1;
          busy_n    = 1'b1;
        end else begin
          state_n = IDLE;
        end
      end

      SHIFT: begin
        a_valid_n = 1'b1;
        busy_n    = 1'b1;
        if (bit_cnt == BCW'(LAST)) begin
          if (rep_cnt != '0) begin
            rep_cnt_n = rep_cnt - REP_W'(1);
            shreg_n   = pat_q;
            bit_cnt_n = '0;
            a_n       = pat_q[N-1];
          end else begin
            state_n   = DONE;
            done_n    = 1'b1;
            a_valid_n = 1'b0;
            busy_n    = 1'b0;
          end
        end else begin
          shreg_n   = {shreg[N-2:0], shreg[N-1]};
          bit_cnt_n = bit_cnt + BCW'(1);
`ifdef SEQ_GEN_PARITY_EN
          if (bit_cnt == BCW'(N - 1)) a_n = ^pat_q;
          else                        a_n = shreg[N-2];
`else
          a_n = shreg[N-2];
`endif
        end
      end

      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_seq_gen.sv
// Self-checking bench for seq_gen: directed steps plus random frames against a queue-based stream model.
module tb_seq_gen;
  localparam int unsigned N     = 3;
  localparam int unsigned REP_W = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [N-1:0]     seq;
  logic [REP_W-1:0] reps;
  logic             ready, a, a_valid, busy, done;

  int passes = 0;
  int checks = 0;
  bit exp_q[$];
  bit obs_q[$];

  always #5 clk = ~clk;

  seq_gen #(.N(N), .REP_W(REP_W)) dut (
    .clk(clk), .reset(reset), .start(start), .seq(seq), .reps(reps),
    .ready(ready), .a(a), .a_valid(a_valid), .busy(busy), .done(done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Expected serial stream: each word MSB first, optionally followed by its even-parity bit.
  task automatic make_expect(input logic [N-1:0] p, input int r);
    exp_q.delete();
    for (int w = 0; w <= r; w++) begin
      for (int i = N - 1; i >= 0; i--) exp_q.push_back(p[i]);
`ifdef SEQ_GEN_PARITY_EN
      exp_q.push_back(bit'($countones(p) % 2));
`endif
    end
  endtask

  // Starts a frame and checks every cycle; hold keeps start high and drives nxt onto seq mid-frame.
  task automatic run_frame(input string tag, input logic [N-1:0] p, input int r,
                           input bit hold, input logic [N-1:0] nxt);
    make_expect(p, r);
    obs_q.delete();
    seq   = p;
    reps  = REP_W'(r);
    start = 1'b1;
    for (int k = 0; k < exp_q.size(); k++) begin
      @(negedge clk);
      if (hold) begin
        seq  = nxt;
        reps = '0;
      end else begin
        start = 1'b0;
        seq   = N'($urandom);
        reps  = REP_W'($urandom);
      end
      if (a_valid) obs_q.push_back(a);
      check({tag, "_a"}, 32'(a), 32'(exp_q[k]));
      check({tag, "_valid"}, 32'(a_valid), 32'd1);
      check({tag, "_busy"}, 32'(busy), 32'd1);
      check({tag, "_done_early"}, 32'(done), 32'd0);
      check({tag, "_ready_busy"}, 32'(ready), 32'd0);
    end
    @(negedge clk);
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_valid_done"}, 32'(a_valid), 32'd0);
    check({tag, "_ready_done"}, 32'(ready), 32'd1);
    if (!hold) begin
      @(negedge clk);
      check({tag, "_done_once"}, 32'(done), 32'd0);
      check({tag, "_ready_idle"}, 32'(ready), 32'd1);
    end
  endtask

  // Counts pattern hits of a sliding N-bit window over a bit stream.
  function automatic int count_hits(input bit q[$], input logic [N-1:0] p);
    int hits = 0;
    for (int e = N - 1; e < q.size(); e++) begin
      logic [N-1:0] win = '0;
      for (int i = 0; i < N; i++) win[N-1-i] = q[e-(N-1)+i];
      if (win == p) hits++;
    end
    return hits;
  endfunction

  initial begin
    reset = 1'b1;
    start = 1'b0;
    seq   = '0;
    reps  = '0;
    repeat (2) @(negedge clk);
    check("rst_a", 32'(a), 32'd0);
    check("rst_valid", 32'(a_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_ready", 32'(ready), 32'd1);
    reset = 1'b0;
    @(negedge clk);

    // Reset in the middle of the second word abandons the frame without a done pulse.
    seq   = 3'b101;
    reps  = 4'd3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("t1_first", 32'(a), 32'd1);
    repeat (4) @(negedge clk);
    check("t1_busy_pre", 32'(busy), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("t1_a", 32'(a), 32'd0);
    check("t1_valid", 32'(a_valid), 32'd0);
    check("t1_busy", 32'(busy), 32'd0);
    check("t1_done", 32'(done), 32'd0);
    check("t1_ready", 32'(ready), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("t1_no_done", 32'(done), 32'd0);
      check("t1_idle_valid", 32'(a_valid), 32'd0);
    end

    run_frame("t2", 3'b010, 0, 1'b0, '0);
    run_frame("t3", 3'b110, 2, 1'b0, '0);

    // Held start: seq drops to 000 mid-frame; next frame accepted in the done cycle.
    run_frame("t4a", 3'b111, 0, 1'b1, 3'b000);
    run_frame("t4b", 3'b000, 0, 1'b0, '0);

    // Loopback stand-in: a sliding-window detector on the observed stream.
    run_frame("t5", 3'b101, 1, 1'b0, '0);
    check("t5_stream_len", 32'(obs_q.size()), 32'(exp_q.size()));
    check("t5_hits", 32'(count_hits(obs_q, 3'b101)), 32'(count_hits(exp_q, 3'b101)));

    run_frame("t6", 3'b011, 0, 1'b0, '0);
    run_frame("max_reps", 3'b100, (1 << REP_W) - 1, 1'b0, '0);

    for (int f = 0; f < 10; f++) begin
      run_frame("rand", N'($urandom), int'($urandom_range(0, 3)), 1'b0, '0);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
